// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative RV32M multiply/divide unit with start/busy/done handshake and flush.
//   Ports: clk, rst_n (async, active-low), start, op[2:0] (funct3), a/b[XLEN-1:0] operands,
//          flush (abort), busy (CALC or FIN), done (1-cycle pulse), result[XLEN-1:0] (held until next done).
//   Optional: define MDU_FAST_MUL_EN to compute multiplies combinationally (1-cycle latency).
module mul_div_unit #(
  parameter int XLEN = 32,
  localparam int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  typedef enum logic [1:0] {IDLE, CALC, FIN} state_e;
  state_e              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                neg_q, neg_d;
  logic [2*XLEN-1:0]   prod_q, prod_d;
  logic [XLEN:0]       rem_q, rem_d;
  logic [XLEN-1:0]     mcand_q, mcand_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic                done_q, done_d;
  logic                sa, sb, dz, ovf;
  logic [XLEN-1:0]     ma, mb;
  logic [XLEN:0]       mul_sum;
  logic [XLEN+1:0]     div_sh, div_df;
  logic [2*XLEN-1:0]   prod_s;
  logic [XLEN-1:0]     quo_s, rem_s;
  // Operand prep: magnitudes of signed operands; the result sign is restored in FIN.
  always_comb begin
    sa = a[XLEN-1] & (op == 3'b001 | op == 3'b010 | (op[2] & ~op[0]));
    sb = b[XLEN-1] & (op == 3'b001 | (op[2] & ~op[0]));
    ma = sa ? -a : a;
    mb = sb ? -b : b;
    dz = op[2] & (b == '0);
    ovf = op[2] & ~op[0] & (a == {1'b1, {(XLEN-1){1'b0}}}) & (&b);
  end
  // Shift-add keeps the multiplier in the low half of prod_q; restoring division
  // keeps the dividend/quotient in the low half and the partial remainder in rem_q.
  always_comb begin
    mul_sum = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    div_sh = {rem_q, prod_q[XLEN-1]};
    div_df = div_sh - {2'b00, mcand_q};
    prod_s = neg_q ? -prod_q : prod_q;
    quo_s = neg_q ? -prod_q[XLEN-1:0] : prod_q[XLEN-1:0];
    rem_s = neg_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
  end
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    cnt_d = cnt_q;
    neg_d = neg_q;
    prod_d = prod_q;
    rem_d = rem_q;
    mcand_d = mcand_q;
    result_d = result_q;
    done_d = 1'b0;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          op_d = op;
          neg_d = (op[2] & op[1]) ? sa : sa ^ sb;
          mcand_d = mb;
          cnt_d = CNT_W'(XLEN);
          prod_d = {{XLEN{1'b0}}, ma};
          rem_d = '0;
          state_d = CALC;
          // Special cases preload quotient/remainder so FIN needs no extra mux.
          if (dz) begin
            neg_d = 1'b0;
            prod_d = {{XLEN{1'b0}}, {XLEN{1'b1}}};
            rem_d = {1'b0, a};
            state_d = FIN;
          end else if (ovf) begin
            neg_d = 1'b0;
            prod_d = {{XLEN{1'b0}}, a};
            state_d = FIN;
          end
`ifdef MDU_FAST_MUL_EN
          if (!op[2]) begin
            prod_d = {{XLEN{1'b0}}, ma} * {{XLEN{1'b0}}, mb};
            state_d = FIN;
          end
`endif
        end
        CALC: begin
          cnt_d = cnt_q - 1'b1;
          if (op_q[2]) begin
            rem_d = div_df[XLEN+1] ? div_sh[XLEN:0] : div_df[XLEN:0];
            prod_d = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-2:0], ~div_df[XLEN+1]};
          end else begin
            prod_d = {mul_sum, prod_q[XLEN-1:1]};
          end
          state_d = (cnt_q == CNT_W'(1)) ? FIN : CALC;
        end
        FIN: begin
          result_d = (op_q == 3'b000) ? prod_s[XLEN-1:0] :
                     !op_q[2]         ? prod_s[2*XLEN-1:XLEN] :
                     op_q[1]          ? rem_s : quo_s;
          done_d = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q <= '0;
      cnt_q <= '0;
      neg_q <= 1'b0;
      prod_q <= '0;
      rem_q <= '0;
      mcand_q <= '0;
      result_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      cnt_q <= cnt_d;
      neg_q <= neg_d;
      prod_q <= prod_d;
      rem_q <= rem_d;
      mcand_q <= mcand_d;
      result_q <= result_d;
      done_q <= done_d;
    end
  end
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign result = result_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed-vector self-checking bench for mul_div_unit.
module tb_mul_div_unit;
`ifdef MDU_FAST_MUL_EN
  localparam int ML = 1;
`else
  localparam int ML = 33;
`endif
  localparam int DL = 33;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        flush = 1'b0;
  logic        busy, done;
  logic [31:0] result;
  int          total = 0;
  int          passed = 0;
  logic [31:0] last_exp = '0;
  mul_div_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .busy(busy), .done(done), .result(result)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else passed++;
  endtask
  task automatic run(input string tag, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] exp, input int lat);
    int n;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1 start = 1'b0;
    check({tag, " busy"}, {31'd0, busy}, 32'd1);
    n = 0;
    while (!done && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
    check({tag, " lat"}, n, lat);
    check(tag, result, exp);
    last_exp = exp;
    @(posedge clk);
    #1 check({tag, " pulse"}, {31'd0, done}, 32'd0);
  endtask
  initial begin
    int n;
    #1 check("rst busy", {31'd0, busy}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    check("rst result", result, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run("mul", 3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, ML);
    run("mulh", 3'b001, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, ML);
    run("mulhu", 3'b011, 32'd7, 32'hFFFFFFFD, 32'h00000006, ML);
    run("mulhsu", 3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, ML);
    run("mulhu2", 3'b011, 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, ML);
    run("div", 3'b100, 32'hFFFFFFEC, 32'd6, 32'hFFFFFFFD, DL);
    run("rem", 3'b110, 32'hFFFFFFEC, 32'd6, 32'hFFFFFFFE, DL);
    run("divu", 3'b101, 32'd20, 32'd6, 32'd3, DL);
    run("remu", 3'b111, 32'd20, 32'd6, 32'd2, DL);
    run("div0", 3'b100, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
    run("rem0", 3'b110, 32'd5, 32'd0, 32'd5, 1);
    run("divu0", 3'b101, 32'd9, 32'd0, 32'hFFFFFFFF, 1);
    run("remu0", 3'b111, 32'd9, 32'd0, 32'd9, 1);
    run("div ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run("rem ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1);
    run("remu big", 3'b111, 32'hFFFFFFFF, 32'h10, 32'd15, DL);
    // flush mid-divide
    @(negedge clk);
    start = 1'b1; op = 3'b101; a = 32'd100; b = 32'd7;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check("flush busy", {31'd0, busy}, 32'd0);
    check("flush done", {31'd0, done}, 32'd0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1 if (done) n++;
    end
    check("flush no done", n, 0);
    check("flush result", result, last_exp);
    run("mul after flush", 3'b000, 32'd3, 32'd4, 32'd12, ML);
    // start held with changing operands while busy
    @(negedge clk);
    start = 1'b1; op = 3'b101; a = 32'd100; b = 32'd7;
    @(posedge clk);
    #1 op = 3'b000; a = 32'd1000; b = 32'd3;
    n = 0;
    while (!done && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
    start = 1'b0;
    check("held lat", n, DL);
    check("held result", result, 32'd14);
    @(negedge clk);
    check("held idle", {31'd0, busy}, 32'd0);
    // async reset mid-CALC
    @(negedge clk);
    start = 1'b1; op = 3'b101; a = 32'd50; b = 32'd5;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("arst busy", {31'd0, busy}, 32'd0);
    check("arst done", {31'd0, done}, 32'd0);
    check("arst result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1 if (done) n++;
    end
    check("arst no done", n, 0);
    run("divu after rst", 3'b101, 32'd50, 32'd5, 32'd10, DL);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
Iterative multi-cycle multiply/divide unit implementing the full RV32M operation set (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU), parametrised in operand width. It sits beside the single-cycle ALU in the execute stage and is selected by the decoder for M-extension instructions. It uses a start/busy/done handshake so the pipeline stalls while busy. A flush input lets a squashed instruction abort the operation.

Parameters:
XLEN, 32, operand and result width in bits (≥8, power of 2)
CNT_W, $clog2(XLEN)+1, iteration counter width (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  operation request; sampled only in IDLE
op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
a  input  XLEN  rs1 operand; captured when start accepted
b  input  XLEN  rs2 operand; captured when start accepted
flush  input  1  abort current operation
busy  output  1  high while an operation is in progress (CALC or FIN)
done  output  1  one-cycle pulse; result valid
result  output  XLEN  result register; holds until next done

Behaviour:
- Reset (rst_n=0, async): state=IDLE, busy=0, done=0, result=0, counter=0, internal registers cleared.
- States: IDLE, CALC, FIN.
- IDLE: start=1 captures op/a/b into registers. Special case → FIN directly. Otherwise → CALC with counter=XLEN. busy goes high the cycle after acceptance.
- Operand prep at acceptance: signed ops take magnitudes. The result sign flag is recorded: MUL* uses signA^signB; DIV uses signA^signB; REM uses signA. MULHSU treats b as unsigned. MUL uses the low half, so sign handling is irrelevant for it.
- CALC, multiply: radix-2 shift-add into a 2*XLEN product register, one bit per cycle.
- CALC, divide: restoring division, one quotient bit per cycle.
- CALC: counter decrements each cycle. When the counter reaches 1, the next state is FIN. Exactly XLEN cycles are spent in CALC.
- FIN: apply two's-complement sign correction, select the output, and load result. done=1 for exactly one cycle, then → IDLE.
  - MUL: low XLEN bits of the product.
  - MULH/MULHSU/MULHU: high XLEN bits of the product.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
- Latency: normal ops assert done XLEN+1 cycles after the start-acceptance edge (33 for XLEN=32). Special cases assert done 1 cycle after acceptance.
- busy=1 in CALC and FIN. Throughput: a new start is accepted in the cycle done is high only if state has returned to IDLE. The next start is therefore accepted the cycle after done.
- Special cases, per RISC-V and with no trap:
  - Divide by zero: DIV/DIVU → all ones; REM/REMU → a.
  - Signed overflow (a=−2^(XLEN−1), b=−1): DIV → a; REM → 0.
- start while busy: ignored, with no side effect.
- flush=1: in any state, next state=IDLE, busy=0 next cycle, no done pulse, result unchanged. flush has priority over start in IDLE.
- flush in the same cycle as FIN: done is suppressed and result is not updated.
- Async reset mid-operation: immediate return to the reset values; no done pulse.
- All arithmetic is modulo 2^XLEN on output; the internal product is 2*XLEN bits wide and the remainder register is XLEN+1 bits wide.

Optional Feature:
MDU_FAST_MUL_EN
- Defined: multiply ops (op[2]=0) bypass CALC. The full 2*XLEN product is computed combinationally from the captured operands, and the state goes directly to FIN. Multiply latency becomes 1 cycle; divide is unchanged.
- Undefined: multiply uses the iterative path with XLEN+1-cycle latency; no wide multiplier is inferred.

Test Plan:
- MUL a=7, b=−3 (0xFFFFFFFD) → done at start+33, result=0xFFFFFFEB; MULH same operands → 0xFFFFFFFF; MULHU → 0x00000006.
- MULHSU a=0x80000000, b=0xFFFFFFFF → result=0x80000000. MULHU with the same operands → 0x7FFFFFFF.
- DIV a=−20, b=6 → 0xFFFFFFFD (−3); REM same operands → 0xFFFFFFFE (−2); DIVU a=20, b=6 → 3; REMU → 2.
- DIV/REM a=5, b=0 → 0xFFFFFFFF / 0x00000005, done 1 cycle after start. DIV a=0x80000000, b=0xFFFFFFFF → 0x80000000; REM → 0.
- Start DIVU, assert flush at cycle 10 → busy=0 next cycle, no done pulse, result keeps its prior value. A new MUL 3×4 issued the cycle after → 12.
- start held high during a busy operation with different operands → the second request is ignored and the first result is correct. Asserting rst_n=0 mid-CALC → busy=0, done=0, result=0 immediately.
